// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: default geometry, requester owner type and read-return tag
// shared by the RAM arbiter slice (ram_arbiter, rr_arb2).
package ram_arb_pkg;

    // Default RAM geometry and read latency (RD_LAT legal range is 1..4).
    localparam int N_DEF      = 3;
    localparam int M_DEF      = 16;
    localparam int RD_LAT_DEF = 1;

    // Which requester issued a command.
    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // One stage of the read-return tag pipeline.
    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

    // Tag value for writes, idle cycles and reset.
    localparam tag_t TAG_IDLE = tag_t'{1'b0, OWN_A};

    // True when a tag carries a read return for the given requester.
    function automatic logic tag_hit(input tag_t tag, input owner_e who);
        return tag.valid && (tag.owner == who);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester grant logic for the RAM arbiter.
// Default build is round-robin with a "last granted" pointer.
// Build option RAM_ARB_FIXED_PRIO_EN: fixed priority, A always beats B,
// no pointer register (B may starve while req_a stays high).
// Grants are combinational and always masked while reset is asserted.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

`ifdef RAM_ARB_FIXED_PRIO_EN

    // Fixed-priority grant: A first, B only when A is not requesting.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!sys_rst_n) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end else if (req_a) begin
            gnt_a = 1'b1;
        end else if (req_b) begin
            gnt_b = 1'b1;
        end else begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end
    end

`else

    owner_e last_r;

    // Round-robin grant: a lone requester wins; on contention the one
    // not granted last wins.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!sys_rst_n) begin
            gnt_a = 1'b0;
            gnt_b = 1'b0;
        end else begin
            case ({req_a, req_b})
                2'b10: gnt_a = 1'b1;
                2'b01: gnt_b = 1'b1;
                2'b11: begin
                    if (last_r == OWN_B) begin
                        gnt_a = 1'b1;
                    end else begin
                        gnt_b = 1'b1;
                    end
                end
                default: begin
                    gnt_a = 1'b0;
                    gnt_b = 1'b0;
                end
            endcase
        end
    end

    // Pointer update: moves only on an accepted command (gnt implies req).
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_r <= OWN_B;
        end else if (gnt_a) begin
            last_r <= OWN_A;
        end else if (gnt_b) begin
            last_r <= OWN_B;
        end else begin
            last_r <= last_r;
        end
    end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter/sequencer in front of a single-port
// synchronous RAM. Accepted commands are registered onto the RAM port one
// cycle after the grant; read data is steered back to the issuing requester
// through a {valid, owner} tag pipeline RD_LAT+1 stages deep.
// Optional macro RAM_ARB_FIXED_PRIO_EN (handled in rr_arb2) selects fixed
// A-over-B priority instead of round-robin.
// sys_rst_n is expected to be released synchronously to sys_clk upstream.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int M      = M_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic         sys_clk,
    input  logic         sys_rst_n,
    input  logic         req_a,
    input  logic         we_a,
    input  logic [N-1:0] addr_a,
    input  logic [M-1:0] din_a,
    input  logic         req_b,
    input  logic         we_b,
    input  logic [N-1:0] addr_b,
    input  logic [M-1:0] din_b,
    output logic         gnt_a,
    output logic         gnt_b,
    output logic         rvalid_a,
    output logic         rvalid_b,
    output logic [M-1:0] rdata_a,
    output logic [M-1:0] rdata_b,
    output logic         ram_we,
    output logic [N-1:0] ram_addr,
    output logic [M-1:0] ram_din,
    input  logic [M-1:0] ram_dout
);

    logic         gnt_a_s;
    logic         gnt_b_s;
    logic         ram_we_r;
    logic [N-1:0] ram_addr_r;
    logic [M-1:0] ram_din_r;
    tag_t         tag_in_s;
    tag_t         tag_r [0:RD_LAT];

    rr_arb2 u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt_a     (gnt_a_s),
        .gnt_b     (gnt_b_s)
    );

    assign gnt_a = gnt_a_s;
    assign gnt_b = gnt_b_s;

    // Command register: load the winner's command; otherwise drop ram_we
    // and hold address/data so the RAM port does not toggle needlessly.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ram_we_r   <= 1'b0;
            ram_addr_r <= {N{1'b0}};
            ram_din_r  <= {M{1'b0}};
        end else if (gnt_a_s) begin
            ram_we_r   <= we_a;
            ram_addr_r <= addr_a;
            ram_din_r  <= din_a;
        end else if (gnt_b_s) begin
            ram_we_r   <= we_b;
            ram_addr_r <= addr_b;
            ram_din_r  <= din_b;
        end else begin
            ram_we_r   <= 1'b0;
            ram_addr_r <= ram_addr_r;
            ram_din_r  <= ram_din_r;
        end
    end

    assign ram_we   = ram_we_r;
    assign ram_addr = ram_addr_r;
    assign ram_din  = ram_din_r;

    // Tag entering the pipeline this cycle: only accepted reads are valid.
    always_comb begin
        tag_in_s = TAG_IDLE;
        if (gnt_a_s) begin
            tag_in_s = tag_t'{!we_a, OWN_A};
        end else if (gnt_b_s) begin
            tag_in_s = tag_t'{!we_b, OWN_B};
        end else begin
            tag_in_s = TAG_IDLE;
        end
    end

    // Tag pipeline: RD_LAT+1 stages so the last stage lines up with the
    // cycle in which ram_dout carries the data for that command.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i <= RD_LAT; i++) begin
                tag_r[i] <= TAG_IDLE;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i <= RD_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Read-return decode from the final (registered) tag stage.
    always_comb begin
        rvalid_a = tag_hit(tag_r[RD_LAT], OWN_A);
        rvalid_b = tag_hit(tag_r[RD_LAT], OWN_B);
    end

    assign rdata_a = ram_dout;
    assign rdata_b = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter. Contains a behavioural
// RAM, a command-level reference model (grant policy, memory image updated in
// grant order, queue of expected read returns), a vector table for the
// contention/hazard cases, hand sequences for reset corners and random traffic.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int N      = N_DEF;
    localparam int M      = M_DEF;
    localparam int RD_LAT = RD_LAT_DEF;

    logic         sys_clk = 1'b0;
    logic         sys_rst_n;
    logic         req_a, we_a, req_b, we_b;
    logic [N-1:0] addr_a, addr_b;
    logic [M-1:0] din_a, din_b;
    logic         gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [M-1:0] rdata_a, rdata_b;
    logic         ram_we;
    logic [N-1:0] ram_addr;
    logic [M-1:0] ram_din;
    logic [M-1:0] ram_dout;

    ram_arbiter #(.N(N), .M(M), .RD_LAT(RD_LAT)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_a     (req_a),
        .we_a      (we_a),
        .addr_a    (addr_a),
        .din_a     (din_a),
        .req_b     (req_b),
        .we_b      (we_b),
        .addr_b    (addr_b),
        .din_b     (din_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .rvalid_a  (rvalid_a),
        .rvalid_b  (rvalid_b),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural single-port synchronous RAM with RD_LAT cycles of read latency.
    logic [M-1:0] mem_ram [0:(1<<N)-1];
    logic [M-1:0] dpipe   [0:RD_LAT-1];

    initial begin
        for (int i = 0; i < (1 << N); i++) mem_ram[i] = '0;
        for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;
    end

    always @(posedge sys_clk) begin
        if (ram_we) mem_ram[ram_addr] <= ram_din;
        dpipe[0] <= mem_ram[ram_addr];
        for (int k = 1; k < RD_LAT; k++) dpipe[k] <= dpipe[k-1];
    end

    assign ram_dout = dpipe[RD_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        bit           own_b;
        logic [M-1:0] data;
    } ret_t;

    ret_t         rq[$];
    logic [M-1:0] mem_m [0:(1<<N)-1];
    bit           last_b_m;
    logic         exp_we;
    logic [N-1:0] exp_addr;
    logic [M-1:0] exp_din;
    int           cyc;
    int           checks;
    int           passed;
    bit           ga, gb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h, want %0h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle: inputs are already set (just after a negedge).
    task automatic step(output bit ga_o, output bit gb_o);
        bit           ev;
        bit           eb;
        logic [M-1:0] ed;
        #1;
        if (!sys_rst_n) begin
            rq.delete();
            exp_we   = 1'b0;
            exp_addr = '0;
            exp_din  = '0;
            last_b_m = 1'b1;
        end
        ga_o = 1'b0;
        gb_o = 1'b0;
        if (sys_rst_n) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
            ga_o = req_a;
            gb_o = req_b && !req_a;
`else
            if (req_a && req_b) begin
                ga_o = last_b_m;
                gb_o = !last_b_m;
            end else begin
                ga_o = req_a;
                gb_o = req_b;
            end
`endif
        end
        ev = (rq.size() > 0) && (rq[0].due == cyc);
        eb = ev ? rq[0].own_b : 1'b0;
        ed = ev ? rq[0].data : '0;
        chk("gnt_a", gnt_a, ga_o);
        chk("gnt_b", gnt_b, gb_o);
        chk("rvalid_a", rvalid_a, ev && !eb);
        chk("rvalid_b", rvalid_b, ev && eb);
        if (ev && !eb) chk("rdata_a", rdata_a, ed);
        if (ev && eb)  chk("rdata_b", rdata_b, ed);
        chk("ram_we", ram_we, exp_we);
        chk("ram_addr", ram_addr, exp_addr);
        if (exp_we) chk("ram_din", ram_din, exp_din);
        @(posedge sys_clk);
        while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
        if (ga_o || gb_o) begin
            logic         w;
            logic [N-1:0] a;
            logic [M-1:0] d;
            w = ga_o ? we_a   : we_b;
            a = ga_o ? addr_a : addr_b;
            d = ga_o ? din_a  : din_b;
            if (w) mem_m[a] = d;
            else   rq.push_back('{cyc + RD_LAT + 1, gb_o, mem_m[a]});
            exp_we   = w;
            exp_addr = a;
            exp_din  = d;
            last_b_m = gb_o;
        end else begin
            exp_we = 1'b0;
        end
        cyc++;
        @(negedge sys_clk);
    endtask

    task automatic set_a(input logic r, input logic w, input logic [N-1:0] a, input logic [M-1:0] d);
        req_a = r; we_a = w; addr_a = a; din_a = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic [N-1:0] a, input logic [M-1:0] d);
        req_b = r; we_b = w; addr_b = a; din_b = d;
    endtask

    typedef struct {
        bit           ra;
        bit           wa;
        logic [N-1:0] aa;
        logic [M-1:0] da;
        bit           rb;
        bit           wb;
        logic [N-1:0] ab;
        logic [M-1:0] db;
        bit           ega;
        bit           egb;
    } vec_t;

    vec_t tbl [13];
    bit   pend_a, pend_b;

    initial begin
        checks = 0; passed = 0; cyc = 0;
        last_b_m = 1'b1; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
        for (int i = 0; i < (1 << N); i++) mem_m[i] = '0;

        // Contention / hazard vectors (pointer preset so A wins the first tie).
        tbl[0]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd5, 16'hB005, 1'b0, 1'b1};
        for (int i = 1; i <= 6; i++)
            tbl[i] = '{1'b1, 1'b0, 3'd2, 16'h0000, 1'b1, 1'b0, 3'd5, 16'h0000, (i % 2) == 1, (i % 2) == 0};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'd3, 16'h0000, 1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'd3, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0};
        for (int i = 10; i <= 12; i++)
            tbl[i] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0};

        // Reset held 3 cycles with A requesting a write of addr 0.
        sys_rst_n = 1'b0;
        set_a(1'b1, 1'b1, 3'd0, 16'hA000);
        set_b(1'b0, 1'b0, 3'd0, 16'h0000);
        @(negedge sys_clk);
        for (int i = 0; i < 3; i++) step(ga, gb);
        sys_rst_n = 1'b1;

        // A-only fill then readback, back to back.
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b1, 3'(i), 16'hA000 + 16'(i));
            step(ga, gb);
        end
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 1'b0, 3'(i), 16'h0000);
            step(ga, gb);
        end
        set_a(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < 3; i++) step(ga, gb);

        // Vector table: contention alternation and same-address hazard.
        for (int i = 0; i < 13; i++) begin
            set_a(tbl[i].ra, tbl[i].wa, tbl[i].aa, tbl[i].da);
            set_b(tbl[i].rb, tbl[i].wb, tbl[i].ab, tbl[i].db);
            #1;
            chk("tbl_gnt_a", gnt_a, tbl[i].ega);
            chk("tbl_gnt_b", gnt_b, tbl[i].egb);
            step(ga, gb);
        end

        // Reset while a read is in flight: no return after release.
        set_a(1'b1, 1'b0, 3'd1, 16'h0000);
        step(ga, gb);
        set_a(1'b0, 1'b0, 3'd0, 16'h0000);
        sys_rst_n = 1'b0;
        step(ga, gb);
        step(ga, gb);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(ga, gb);

        // Both held high for 6 cycles, then A drops.
        set_a(1'b1, 1'b0, 3'd4, 16'h0000);
        set_b(1'b1, 1'b0, 3'd6, 16'h0000);
        for (int i = 0; i < 6; i++) step(ga, gb);
        set_a(1'b0, 1'b0, 3'd0, 16'h0000);
        step(ga, gb);
        set_b(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < 3; i++) step(ga, gb);

        // Random traffic: pending requests are usually held, sometimes dropped.
        pend_a = 1'b0; pend_b = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(pend_a && $urandom_range(7, 0) != 0))
                set_a($urandom_range(9, 0) < 7, 1'($urandom_range(1, 0)),
                      3'($urandom_range(7, 0)), 16'($urandom()));
            if (!(pend_b && $urandom_range(7, 0) != 0))
                set_b($urandom_range(9, 0) < 7, 1'($urandom_range(1, 0)),
                      3'($urandom_range(7, 0)), 16'($urandom()));
            step(ga, gb);
            pend_a = req_a && !ga;
            pend_b = req_b && !gb;
        end
        set_a(1'b0, 1'b0, 3'd0, 16'h0000);
        set_b(1'b0, 1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < 4; i++) step(ga, gb);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
